// File: rtl/arith_shift_pkg.sv
// rtl/arith_shift_pkg.sv - shared configuration types and constants for arith_shift_pipe
// Build option SHIFTER_SAT_EN (see arith_shift_lane) does not affect this package.
package arith_shift_pkg;

   localparam int OVF_CNT_W   = 16;
   localparam int CFG_SHIFT_W = 8;

   typedef struct packed {
      logic [CFG_SHIFT_W-1:0] shift;
      logic                   dir;
      logic                   round;
   } cfg_t;

   localparam cfg_t CFG_RESET = '{shift: '0, dir: 1'b0, round: 1'b0};

endpackage

// File: rtl/arith_shift_lane.sv
// rtl/arith_shift_lane.sv - two-stage arithmetic shifter datapath for one channel
// SHIFTER_SAT_EN defined: left-shift overflow clamps; undefined: left shift wraps.
module arith_shift_lane
   import arith_shift_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             en1,
   input  logic             en2,
   input  logic [WIDTH-1:0] x,
   input  cfg_t             cfg,
   output logic [WIDTH-1:0] y,
   output logic             sat
);

   localparam logic [CFG_SHIFT_W-1:0] WIDTH_S = CFG_SHIFT_W'(WIDTH);
   localparam logic [CFG_SHIFT_W-1:0] ONE_S   = CFG_SHIFT_W'(1);

   // True when the top k+1 bits of val all match, i.e. val <<< k loses nothing.
   function automatic logic top_uniform(input logic [WIDTH-1:0] val,
                                        input logic [CFG_SHIFT_W-1:0] k);
      logic [WIDTH-1:0] m;
      m = ~({WIDTH{1'b1}} >> (k + ONE_S));
      return ((val & m) == m) || ((val & m) == '0);
   endfunction

   logic                   big;
   logic [CFG_SHIFT_W-1:0] coarse;
   logic signed [WIDTH:0]  xe;
   logic signed [WIDTH:0]  inc;
   logic signed [WIDTH:0]  v;
   logic signed [WIDTH:0]  d1_n;
   logic                   ovf1_n;

   always_comb begin
      big    = (cfg.shift >= WIDTH_S);
      coarse = {cfg.shift[CFG_SHIFT_W-1:2], 2'b00};
      xe     = {x[WIDTH-1], x};
      inc    = '0;
      if (cfg.round && !cfg.dir && (cfg.shift != '0) && !big)
         inc = (WIDTH+1)'(1) << (cfg.shift - ONE_S);
      // one extra bit keeps x + half-LSB from wrapping at the positive limit
      v      = xe + inc;
      ovf1_n = 1'b0;
      if (cfg.dir) begin
         d1_n   = {1'b0, x << coarse};
         ovf1_n = !big && !top_uniform(x, coarse);
      end else begin
         d1_n   = v >>> coarse;
      end
   end

   logic signed [WIDTH:0] d1;
   logic                  ovf1;
   logic                  sgn1;
   logic                  nz1;
   logic                  dir1;
   logic                  big1;
   logic [1:0]            fine1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         d1    <= '0;
         ovf1  <= 1'b0;
         sgn1  <= 1'b0;
         nz1   <= 1'b0;
         dir1  <= 1'b0;
         big1  <= 1'b0;
         fine1 <= '0;
      end else if (en1) begin
         d1    <= d1_n;
         ovf1  <= ovf1_n;
         sgn1  <= x[WIDTH-1];
         nz1   <= |x;
         dir1  <= cfg.dir;
         big1  <= big;
         fine1 <= cfg.shift[1:0];
      end
   end

   logic [WIDTH-1:0] lsh;
   logic [WIDTH-1:0] y_n;
   logic             ovf2;

   always_comb begin
      lsh  = d1[WIDTH-1:0] << fine1;
      y_n  = WIDTH'(d1 >>> fine1);
      ovf2 = 1'b0;
      if (big1) begin
         if (dir1) begin
            y_n  = '0;
            ovf2 = nz1;
         end else begin
            y_n  = {WIDTH{sgn1}};
         end
      end else if (dir1) begin
         y_n  = lsh;
         ovf2 = ovf1 || !top_uniform(d1[WIDTH-1:0], CFG_SHIFT_W'(fine1));
      end
`ifdef SHIFTER_SAT_EN
      if (ovf2)
         y_n = sgn1 ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         y   <= '0;
         sat <= 1'b0;
      end else if (en2) begin
         y   <= y_n;
         sat <= ovf2;
      end
   end

endmodule

// File: rtl/arith_shift_pipe.sv
// rtl/arith_shift_pipe.sv - multi-channel pipelined arithmetic shifter with overflow counter
// SHIFTER_SAT_EN selects saturating left shifts in every lane.
module arith_shift_pipe
   import arith_shift_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2,
   parameter int SHIFT_W  = $clog2(WIDTH) + 1
)
(
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic                        cfg_we_i,
   input  logic [SHIFT_W-1:0]          cfg_shift_i,
   input  logic                        cfg_dir_i,
   input  logic                        cfg_round_i,
   input  logic                        clr_i,
   input  logic                        valid_i,
   input  logic [CHANNELS*WIDTH-1:0]   data_i,
   output logic                        valid_o,
   output logic [CHANNELS*WIDTH-1:0]   data_o,
   output logic [CHANNELS-1:0]         sat_o,
   output logic [OVF_CNT_W-1:0]        ovf_cnt_o
);

   cfg_t                cfg_q;
   logic                v1;
   logic [CHANNELS-1:0] sat_q;

   // A write lands after the edge, so a sample in the same cycle still sees the old value.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cfg_q <= CFG_RESET;
      end else if (cfg_we_i) begin
         cfg_q <= '{shift: CFG_SHIFT_W'(cfg_shift_i), dir: cfg_dir_i, round: cfg_round_i};
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         v1      <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         v1      <= valid_i;
         valid_o <= v1;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      arith_shift_lane #(.WIDTH(WIDTH)) u_lane (
         .clk  (clk_i),
         .rstn (rstn_i),
         .en1  (valid_i),
         .en2  (v1),
         .x    (data_i[g*WIDTH +: WIDTH]),
         .cfg  (cfg_q),
         .y    (data_o[g*WIDTH +: WIDTH]),
         .sat  (sat_q[g])
      );
   end

   assign sat_o = valid_o ? sat_q : '0;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ovf_cnt_o <= '0;
      end else if (clr_i) begin
         ovf_cnt_o <= '0;
      end else if (valid_o && (|sat_q) && (ovf_cnt_o != '1)) begin
         ovf_cnt_o <= ovf_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_arith_shift_pipe.sv
// tb/tb_arith_shift_pipe.sv - self-checking bench for arith_shift_pipe (WIDTH=32, CHANNELS=2)
module tb_arith_shift_pipe;

   logic        clk = 1'b0;
   logic        rstn_i = 1'b0;
   logic        cfg_we_i = 1'b0;
   logic [5:0]  cfg_shift_i = '0;
   logic        cfg_dir_i = 1'b0;
   logic        cfg_round_i = 1'b0;
   logic        clr_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [63:0] data_i = '0;
   logic        valid_o;
   logic [63:0] data_o;
   logic [1:0]  sat_o;
   logic [15:0] ovf_cnt_o;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   arith_shift_pipe #(.WIDTH(32), .CHANNELS(2)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn_i),
      .cfg_we_i    (cfg_we_i),
      .cfg_shift_i (cfg_shift_i),
      .cfg_dir_i   (cfg_dir_i),
      .cfg_round_i (cfg_round_i),
      .clr_i       (clr_i),
      .valid_i     (valid_i),
      .data_i      (data_i),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .sat_o       (sat_o),
      .ovf_cnt_o   (ovf_cnt_o)
   );

   typedef struct {
      logic [5:0]  shift;
      logic        dir;
      logic        rnd;
      logic [31:0] x0;
      logic [31:0] x1;
      logic [31:0] e0w;
      logic [31:0] e1w;
      logic [31:0] e0s;
      logic [31:0] e1s;
      logic [1:0]  sat;
   } vec_t;

   localparam int NV = 15;
   localparam int NR = 24;
   vec_t vecs[NV];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Wide-integer reference: {overflow, result}
   function automatic logic [32:0] model(input logic [31:0] x, input int s,
                                         input logic dir, input logic rnd);
      longint xv;
      longint p;
      logic ovf;
      logic [31:0] y;
      xv  = longint'($signed(x));
      ovf = 1'b0;
      if (!dir) begin
         if (s >= 32) y = x[31] ? 32'hFFFFFFFF : 32'h0;
         else if (rnd && s > 0) begin p = (xv + (64'sd1 <<< (s - 1))) >>> s; y = p[31:0]; end
         else begin p = xv >>> s; y = p[31:0]; end
      end else begin
         if (s >= 32) begin ovf = (x != 0); y = 32'h0; end
         else begin
            p   = xv <<< s;
            ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            y   = p[31:0];
         end
`ifdef SHIFTER_SAT_EN
         if (ovf) y = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
      end
      return {ovf, y};
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      logic [63:0] exp;
`ifdef SHIFTER_SAT_EN
      exp = {v.e1s, v.e0s};
`else
      exp = {v.e1w, v.e0w};
`endif
      @(negedge clk);
      cfg_we_i = 1'b1; cfg_shift_i = v.shift; cfg_dir_i = v.dir; cfg_round_i = v.rnd;
      @(negedge clk);
      cfg_we_i = 1'b0; valid_i = 1'b1; data_i = {v.x1, v.x0};
      @(posedge clk); #1;
      chk($sformatf("v%0d_early_valid", idx), valid_o, 0);
      @(negedge clk);
      valid_i = 1'b0; data_i = '0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", idx), valid_o, 1);
      chk($sformatf("v%0d_data", idx), data_o, exp);
      chk($sformatf("v%0d_sat", idx), sat_o, v.sat);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_drop", idx), valid_o, 0);
      chk($sformatf("v%0d_sat_idle", idx), sat_o, 0);
      chk($sformatf("v%0d_data_hold", idx), data_o, exp);
   endtask

   initial begin
      int          stab[8];
      logic [32:0] m0[NR];
      logic [32:0] m1[NR];
      int          cur_s;
      logic        cur_d, cur_r;
      int          nov;
      logic [31:0] x0, x1;

      vecs[0]  = '{6'd0,  1'b0, 1'b0, 32'h00001234, 32'hFFFFFFF0, 32'h00001234, 32'hFFFFFFF0, 32'h00001234, 32'hFFFFFFF0, 2'b00};
      vecs[1]  = '{6'd4,  1'b0, 1'b0, 32'hFFFFFFEF, 32'h00000018, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 2'b00};
      vecs[2]  = '{6'd4,  1'b0, 1'b1, 32'hFFFFFFEF, 32'h00000018, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'h00000002, 2'b00};
      vecs[3]  = '{6'd1,  1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000, 2'b00};
      vecs[4]  = '{6'd8,  1'b1, 1'b0, 32'h00800000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFF00, 32'h7FFFFFFF, 32'hFFFFFF00, 2'b01};
      vecs[5]  = '{6'd40, 1'b0, 1'b0, 32'hFFFFFFFB, 32'h00000005, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 2'b00};
      vecs[6]  = '{6'd40, 1'b1, 1'b0, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000000, 2'b01};
      vecs[7]  = '{6'd40, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 2'b00};
      vecs[8]  = '{6'd7,  1'b1, 1'b0, 32'hFF000000, 32'hFE000000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 2'b10};
      vecs[9]  = '{6'd3,  1'b1, 1'b0, 32'h0FFFFFFF, 32'h10000000, 32'h7FFFFFF8, 32'h80000000, 32'h7FFFFFF8, 32'h7FFFFFFF, 2'b10};
      vecs[10] = '{6'd0,  1'b0, 1'b1, 32'h00000003, 32'h80000000, 32'h00000003, 32'h80000000, 32'h00000003, 32'h80000000, 2'b00};
      vecs[11] = '{6'd31, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 2'b00};
      vecs[12] = '{6'd31, 1'b0, 1'b1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 2'b00};
      vecs[13] = '{6'd32, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000, 2'b01};
      vecs[14] = '{6'd5,  1'b1, 1'b1, 32'h00000003, 32'hFFFFFFE1, 32'h00000060, 32'hFFFFFC20, 32'h00000060, 32'hFFFFFC20, 2'b00};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_sat", sat_o, 0);
      chk("rst_cnt", ovf_cnt_o, 0);
      @(negedge clk);
      rstn_i = 1'b1;

      // first vector relies on the reset (pass-through) config, no write needed
      @(negedge clk);
      valid_i = 1'b1; data_i = {32'hFFFFFFF0, 32'h00001234};
      @(negedge clk);
      valid_i = 1'b0;
      @(posedge clk); #1;
      chk("default_valid", valid_o, 1);
      chk("default_data", data_o, {32'hFFFFFFF0, 32'h00001234});
      chk("default_sat", sat_o, 0);

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);
      chk("table_ovf_cnt", ovf_cnt_o, 5);

      // clear, then config rewritten every cycle against a ramp
      @(negedge clk);
      clr_i = 1'b1; cfg_we_i = 1'b1; cfg_shift_i = 6'd0; cfg_dir_i = 1'b0; cfg_round_i = 1'b0;
      @(negedge clk);
      clr_i = 1'b0; cfg_we_i = 1'b0;
      chk("clr_idle", ovf_cnt_o, 0);
      stab = '{0, 1, 4, 5, 8, 31, 33, 3};
      cur_s = 0; cur_d = 1'b0; cur_r = 1'b0; nov = 0;
      for (int i = 0; i < NR + 1; i++) begin
         if (i > 0) @(negedge clk);
         if (i < NR) begin
            x0 = 32'h00F00000 + 32'(i) * 32'h00123457;
            x1 = 32'h0 - x0;
            m0[i] = model(x0, cur_s, cur_d, cur_r);
            m1[i] = model(x1, cur_s, cur_d, cur_r);
            valid_i = 1'b1; data_i = {x1, x0};
            cfg_we_i = 1'b1; cfg_shift_i = 6'(stab[i % 8]);
            cfg_dir_i = (i % 3 == 1); cfg_round_i = (i % 2 == 0);
            cur_s = stab[i % 8]; cur_d = (i % 3 == 1); cur_r = (i % 2 == 0);
         end else begin
            valid_i = 1'b0; cfg_we_i = 1'b0;
         end
         @(posedge clk); #1;
         if (i >= 1) begin
            chk($sformatf("ramp%0d_valid", i - 1), valid_o, 1);
            chk($sformatf("ramp%0d_data", i - 1), data_o, {m1[i-1][31:0], m0[i-1][31:0]});
            chk($sformatf("ramp%0d_sat", i - 1), sat_o, {m1[i-1][32], m0[i-1][32]});
            nov += int'(m0[i-1][32] | m1[i-1][32]);
         end
      end
      @(posedge clk); #1;
      chk("ramp_valid_drop", valid_o, 0);
      chk("ramp_ovf_cnt", ovf_cnt_o, 16'(nov));

      // counter saturation
      @(negedge clk);
      cfg_we_i = 1'b1; cfg_shift_i = 6'd40; cfg_dir_i = 1'b1; cfg_round_i = 1'b0;
      @(negedge clk);
      cfg_we_i = 1'b0; clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0; valid_i = 1'b1; data_i = {32'h5, 32'h1};
      repeat (70000) @(negedge clk);
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("cnt_saturated", ovf_cnt_o, 16'hFFFF);

      // clear, count three, then clr coinciding with an overflowing valid_o
      @(negedge clk);
      clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0;
      chk("cnt_cleared", ovf_cnt_o, 0);
      valid_i = 1'b1;
      repeat (3) @(negedge clk);
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("cnt_three", ovf_cnt_o, 3);
      @(negedge clk);
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      @(posedge clk); #1;
      chk("clr_coinc_valid", valid_o, 1);
      chk("clr_coinc_sat", sat_o, 2'b11);
      @(negedge clk);
      clr_i = 1'b1;
      @(posedge clk); #1;
      chk("clr_priority", ovf_cnt_o, 0);
      @(negedge clk);
      clr_i = 1'b0;

      // reset with the pipe full
      valid_i = 1'b1; data_i = {32'h7, 32'h9};
      @(posedge clk);
      @(posedge clk);
      #2;
      rstn_i = 1'b0;
      #1;
      chk("midrst_valid", valid_o, 0);
      chk("midrst_data", data_o, 0);
      chk("midrst_sat", sat_o, 0);
      chk("midrst_cnt", ovf_cnt_o, 0);
      @(negedge clk);
      valid_i = 1'b0;
      rstn_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("postrst_valid%0d", k), valid_o, 0);
      end
      chk("postrst_data", data_o, 0);

      // config must be back to pass-through
      @(negedge clk);
      valid_i = 1'b1; data_i = {32'h80000001, 32'h00001234};
      @(negedge clk);
      valid_i = 1'b0;
      @(posedge clk); #1;
      chk("postrst_pass_valid", valid_o, 1);
      chk("postrst_pass_data", data_o, {32'h80000001, 32'h00001234});
      chk("postrst_pass_sat", sat_o, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/arith_shift_pipe.md
# arith_shift_pipe

Pipelined, multi-channel arithmetic shifter with a run-time programmable shift amount and direction, optional round-half-up on right shifts, and optional saturation on left shifts. It sits in the feedback/gain-scaling path between the ADC-side filters and the DAC-side summers. It replaces fixed compile-time scaling with a register-controlled one that can change mid-stream without glitching samples already in flight.

## Interface
- WIDTH, 32, sample width per channel (signed two's complement), ≥4
- CHANNELS, 2, independent lanes sharing one shift configuration
- SHIFT_W, $clog2(WIDTH)+1, width of shift-amount field (can express 0..WIDTH and beyond)
- clk_i  in  1  system clock, all logic rising-edge
- rstn_i  in  1  asynchronous active-low reset
- cfg_we_i  in  1  load cfg_* into configuration register
- cfg_shift_i  in  SHIFT_W  unsigned shift amount
- cfg_dir_i  in  1  0 = arithmetic right, 1 = left
- cfg_round_i  in  1  1 = round-half-up on right shift
- clr_i  in  1  synchronous clear of ovf_cnt_o
- valid_i  in  1  input sample strobe
- data_i  in  CHANNELS*WIDTH  packed samples, lane 0 in LSBs
- valid_o  out  1  output sample strobe
- data_o  out  CHANNELS*WIDTH  shifted samples, same packing
- sat_o  out  CHANNELS  per-lane overflow flag, qualified by valid_o
- ovf_cnt_o  out  16  saturating count of output samples with any sat_o bit set

## Operation
- Config register (shift, dir, round) resets to shift=0, dir=0, round=0 (pass-through). Loaded on cfg_we_i; applies to samples with valid_i on the following cycle or later.
- Config is sampled alongside data at stage 1 and travels down the pipe with it. A config change never affects in-flight samples.
- Right shift, s = shift: result = floor(x / 2^s). With round and s ≥ 1: result = floor((x + 2^(s-1)) / 2^s), computed in WIDTH+1 bits so that no intermediate overflow occurs. s = 0 ignores round. s ≥ WIDTH gives 0 for x ≥ 0 and −1 for x < 0 (round never lifts the result above 0 here).
- Left shift: result = x · 2^s truncated to WIDTH. Overflow occurs when the discarded bits plus the new MSB are not all equal to the sign bit. s ≥ WIDTH overflows for every x ≠ 0. sat_o and saturation behaviour are set by Configuration.
- ovf_cnt_o increments on each valid_o cycle with |sat_o = 1 and holds at 0xFFFF. clr_i takes priority over an increment in the same cycle (result 0).
- valid_i = 0 samples are not processed. data_o holds its last value and sat_o is forced to 0 when valid_o = 0.

## Timing
- Fixed latency of 2 cycles valid_i → valid_o. Full throughput of one sample per cycle, no backpressure.
- Stage 1 registers: coarse shift by the upper bits of shift (multiples of 4), the rounding increment, and the overflow pre-detect. Stage 2 registers: fine shift (0–3), final overflow, and saturation.
- Reset values: valid_o = 0, data_o = 0, sat_o = 0, ovf_cnt_o = 0, config = pass-through. Reset mid-stream drops all in-flight samples; no valid_o is produced for them.
- cfg_we_i and valid_i in the same cycle: that sample uses the old config.

## Configuration
- SHIFTER_SAT_EN defined: a left-shift overflow clamps the lane to 2^(WIDTH-1)−1 (x > 0) or −2^(WIDTH-1) (x < 0) and sets that sat_o bit.
- SHIFTER_SAT_EN undefined: left shift wraps, identical to truncating <<<. Overflow still sets sat_o and still counts in ovf_cnt_o, so detection is always present.

## Structure
- Shared package arith_shift_pkg holds a cfg_t struct (shift, dir, round), OVF_CNT_W = 16, and the pass-through reset constant CFG_RESET.
- One sub-module, arith_shift_lane, implements the two-stage datapath for a single channel. The top instantiates CHANNELS lanes and owns the config register, valid pipe, and counter.

## Test plan
- Reset then valid_i with x = 0x00001234, default config → same value out exactly 2 cycles later, sat_o = 0.
- Right shift, WIDTH=32, s = 4: x = −17 → −2. With round: x = −17 → −1, x = 24 → 2 (24/16 = 1.5 rounds up), x = 0x7FFFFFFF, s = 1 → 0x40000000.
- Left shift, s = 8: x = 0x00800000 → overflow, sat_o = 1. With SHIFTER_SAT_EN the result is 0x7FFFFFFF; without it, 0x80000000. x = −1 → −256, no overflow.
- s = 40: right on x = −5 gives −1; left on x = 1 gives overflow, sat_o = 1.
- Config written every cycle during continuous valid_i with a ramp input → each output matches the config in force at its input cycle; no mixed-config sample.
- 70000 consecutive overflowing samples → ovf_cnt_o = 0xFFFF. clr_i together with an overflowing valid_o → 0. Assert rstn_i mid-stream → valid_o low and no stale outputs afterwards.
